// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequences the PC, reads a 1-cycle-latency ROM and
// hands each instruction to the decoder under a valid/ready handshake.
// Also accepts branch redirects and halt requests, and counts retired words.
module instr_fetch #(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned INSTR_W = 9,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               halt_req,
  output logic               done,
  output logic [PC_W-1:0]    pc,
  output logic [CNT_W-1:0]   instr_count
);

  typedef enum logic [1:0] {StIdle, StReq, StHold, StDone} state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               xfer;

  // valid_q is only ever set in HOLD, so this is the handshake edge.
  assign xfer = valid_q & instr_ready;

  // Next-state logic for the fetch sequencer and its datapath registers.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StReq;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      StReq: begin
        // ROM data for pc is available at this edge.
        instr_d = imem_rdata;
        valid_d = 1'b1;
        state_d = StHold;
      end
      StHold: begin
        if (xfer) begin
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          valid_d = 1'b0;
          // Halt takes priority over a simultaneous branch.
          if (halt_req) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else if (branch_taken) begin
            pc_d    = branch_target;
            state_d = StReq;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = StReq;
          end
        end
      end
      StDone: begin
        if (start) begin
          state_d = StReq;
          pc_d    = '0;
          done_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any in-flight fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign done        = done_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch. A second instance with a
// 4-bit counter shares all stimulus so counter saturation is reachable quickly.
module tb_instr_fetch;

  localparam int unsigned PC_W    = 10;
  localparam int unsigned INSTR_W = 9;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [PC_W-1:0]    imem_addr, imem_addr_s;
  logic [INSTR_W-1:0] imem_rdata, imem_rdata_s;
  logic [INSTR_W-1:0] instr, instr_s;
  logic               instr_valid, instr_valid_s;
  logic               instr_ready;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic               halt_req;
  logic               done, done_s;
  logic [PC_W-1:0]    pc, pc_s;
  logic [15:0]        instr_count;
  logic [3:0]         instr_count_s;

  logic [INSTR_W-1:0] rom [0:1023];

  int n_checks;
  int n_errors;

  // ROM model: data for the presented address is ready by the next edge.
  assign imem_rdata   = rom[imem_addr];
  assign imem_rdata_s = rom[imem_addr_s];

  instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .halt_req     (halt_req),
    .done         (done),
    .pc           (pc),
    .instr_count  (instr_count)
  );

  instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(4)) dut_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .imem_addr    (imem_addr_s),
    .imem_rdata   (imem_rdata_s),
    .instr        (instr_s),
    .instr_valid  (instr_valid_s),
    .instr_ready  (instr_ready),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .halt_req     (halt_req),
    .done         (done_s),
    .pc           (pc_s),
    .instr_count  (instr_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    start         = 1'b0;
    instr_ready   = 1'b1;
    branch_taken  = 1'b0;
    branch_target = '0;
    halt_req      = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = INSTR_W'(i * 7 + 3);
    rom[0] = 9'h041;
    rom[1] = 9'h0C2;
    rom[2] = 9'h183;
    rom[3] = 9'h1C4;

    // Reset state
    #12;
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_pc", 32'(pc), 32'd0);
    check_eq("rst_instr", 32'(instr), 32'd0);
    check_eq("rst_count", 32'(instr_count), 32'd0);
    rst_n = 1'b1;
    step();
    check_eq("idle_valid", 32'(instr_valid), 32'd0);

    // Start: first valid two edges after start is sampled
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("req_valid", 32'(instr_valid), 32'd0);
    check_eq("req_addr", 32'(imem_addr), 32'd0);
    step();
    check_eq("i0_valid", 32'(instr_valid), 32'd1);
    check_eq("i0_instr", 32'(instr), 32'h041);
    check_eq("i0_pc", 32'(pc), 32'd0);
    step();
    check_eq("x0_valid", 32'(instr_valid), 32'd0);
    check_eq("x0_count", 32'(instr_count), 32'd1);
    check_eq("x0_pc", 32'(pc), 32'd1);
    step();
    check_eq("i1_instr", 32'(instr), 32'h0C2);

    // Backpressure with a stray branch and start during the stall
    instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      branch_taken  = (k == 2);
      start         = (k == 3);
      branch_target = 10'h055;
      step();
      check_eq("stall_instr", 32'(instr), 32'h0C2);
      check_eq("stall_pc", 32'(pc), 32'd1);
      check_eq("stall_valid", 32'(instr_valid), 32'd1);
    end
    branch_taken = 1'b0;
    start        = 1'b0;
    check_eq("stall_count", 32'(instr_count), 32'd1);
    instr_ready = 1'b1;
    step();
    check_eq("x1_pc", 32'(pc), 32'd2);
    check_eq("x1_count", 32'(instr_count), 32'd2);
    step();
    check_eq("i2_instr", 32'(instr), 32'h183);
    step();
    step();
    check_eq("i3_instr", 32'(instr), 32'h1C4);
    check_eq("i3_pc", 32'(pc), 32'd3);
    step();
    check_eq("x3_count", 32'(instr_count), 32'd4);
    step();  // HOLD pc4
    step();  // transfer -> pc5
    step();  // HOLD pc5
    check_eq("b_pc", 32'(pc), 32'd5);

    // Branch at pc=5
    branch_taken  = 1'b1;
    branch_target = 10'h020;
    step();
    branch_taken = 1'b0;
    check_eq("br_addr", 32'(imem_addr), 32'h020);
    check_eq("br_valid", 32'(instr_valid), 32'd0);
    check_eq("br_count", 32'(instr_count), 32'd6);
    step();
    check_eq("br_instr", 32'(instr), 32'(rom[10'h020]));
    check_eq("br_ivalid", 32'(instr_valid), 32'd1);

    // Get to pc=7, then halt together with a branch
    branch_taken  = 1'b1;
    branch_target = 10'd7;
    step();
    branch_taken = 1'b0;
    step();
    check_eq("h_pc", 32'(pc), 32'd7);
    halt_req      = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 10'h100;
    step();
    halt_req     = 1'b0;
    branch_taken = 1'b0;
    check_eq("halt_done", 32'(done), 32'd1);
    check_eq("halt_valid", 32'(instr_valid), 32'd0);
    check_eq("halt_pc", 32'(pc), 32'd7);
    check_eq("halt_count", 32'(instr_count), 32'd8);
    step();
    step();
    check_eq("done_sticky", 32'(done), 32'd1);
    check_eq("done_pc", 32'(pc), 32'd7);

    // Restart from DONE
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("rs_done", 32'(done), 32'd0);
    check_eq("rs_pc", 32'(pc), 32'd0);
    check_eq("rs_count", 32'(instr_count), 32'd0);
    step();
    check_eq("rs_instr", 32'(instr), 32'h041);

    // PC wrap
    branch_taken  = 1'b1;
    branch_target = 10'h3FF;
    step();
    branch_taken = 1'b0;
    check_eq("wr_pc", 32'(pc), 32'h3FF);
    step();
    check_eq("wr_instr", 32'(instr), 32'(rom[10'h3FF]));
    step();
    check_eq("wrap_pc", 32'(pc), 32'h000);
    check_eq("wrap_count", 32'(instr_count), 32'd2);

    // 20 more transfers: 16-bit count reaches 22, 4-bit count pins at 15
    for (int k = 0; k < 40; k++) step();
    check_eq("run_count", 32'(instr_count), 32'd22);
    check_eq("sat_count", 32'(instr_count_s), 32'd15);
    check_eq("run_pc", 32'(pc), 32'd20);

    // Async reset mid-HOLD
    step();
    check_eq("pre_rst_valid", 32'(instr_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(instr_valid), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    check_eq("arst_pc", 32'(pc), 32'd0);
    check_eq("arst_instr", 32'(instr), 32'd0);
    check_eq("arst_count", 32'(instr_count), 32'd0);
    #1;
    rst_n = 1'b1;
    step();
    step();
    check_eq("post_valid", 32'(instr_valid), 32'd0);
    check_eq("post_pc", 32'(pc), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch unit for the R.O.E 9-bit core; producer end of the `instr[8:0]` bus that the control decoder consumes.
- Sequences the PC, reads a synchronous 1-cycle-latency instruction ROM, and presents each word to decode/execute under a valid/ready handshake.
- Accepts a branch redirect and a halt request from the datapath, and counts retired instructions.

Parameters:
- PC_W, 10, program counter / instruction-memory address width.
- INSTR_W, 9, instruction width; must match the decoder's `instr` width.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin or restart execution at PC 0; pulse, sampled only in IDLE and DONE.
- imem_addr  out  PC_W  ROM address; combinationally equal to pc.
- imem_rdata  in  INSTR_W  ROM data; valid one cycle after imem_addr is presented.
- instr  out  INSTR_W  instruction to the decoder; registered, stable while instr_valid=1.
- instr_valid  out  1  instr holds a live instruction.
- instr_ready  in  1  consumer accepts instr this cycle.
- branch_taken  in  1  accepted instruction is a taken branch; meaningful only on handshake.
- branch_target  in  PC_W  redirect address; meaningful only with branch_taken on handshake.
- halt_req  in  1  accepted instruction ends the program; meaningful only on handshake.
- done  out  1  program halted; sticky.
- pc  out  PC_W  current program counter.
- instr_count  out  CNT_W  number of handshakes completed since the last start.

Behaviour:
- Reset (async, immediate, any state, including mid-handshake): state=IDLE, pc=0, instr=0, instr_valid=0, done=0, instr_count=0. Any outstanding ROM read is discarded.
- Handshake: a transfer occurs on a rising edge where instr_valid=1 and instr_ready=1. branch_taken, branch_target and halt_req are sampled only on that edge; outside a transfer they are ignored.
- FSM states: IDLE, REQ, HOLD, DONE.
- IDLE: all outputs at reset values.
  - start=1 -> REQ; pc=0, instr_count=0.
- REQ: imem_addr=pc is presented for one cycle.
  - Next edge: instr<=imem_rdata, instr_valid<=1, -> HOLD.
  - start is ignored.
- HOLD: instr_valid=1; instr is held constant until a transfer.
  - No transfer: stay in HOLD; pc unchanged.
  - On transfer: instr_count += 1, saturating at 2^CNT_W-1 (no wrap). Then, in priority order:
    - halt_req=1 -> DONE; instr_valid<=0, done<=1, pc unchanged. Halt wins over branch_taken in the same cycle.
    - else branch_taken=1 -> pc<=branch_target, instr_valid<=0, -> REQ.
    - else pc<=pc+1, modulo 2^PC_W (2^PC_W-1 wraps to 0), instr_valid<=0, -> REQ.
  - start is ignored.
- DONE: done=1, instr_valid=0; pc and instr_count are held for inspection.
  - start=1 -> REQ; pc=0, done<=0, instr_count<=0.
- Latency:
  - start to first instr_valid: 2 edges.
  - Transfer to next instr_valid: 2 edges.
  - Peak throughput: 1 instruction per 2 cycles.
  - A branch costs no extra cycle beyond this.
- instr is updated only on the REQ->HOLD edge. instr_valid is never asserted in IDLE, REQ or DONE.

Test Plan:
- Reset then start pulse, ROM[0..3]=9'h041,9'h0C2,9'h183,9'h1C4, instr_ready tied 1 -> instr_valid first high 2 cycles after start; instr sequence 041,0C2,183,1C4; pc 0,1,2,3; instr_count=4 after the fourth transfer.
- Backpressure: hold instr_ready=0 for 5 cycles in HOLD with instr=9'h0C2 -> instr, pc and instr_valid stable for all 5 cycles; branch_taken=1 pulsed during the stall has no effect; release -> pc advances to 2.
- Branch: on transfer at pc=5, branch_taken=1, branch_target=10'h020 -> imem_addr=0x020 next cycle; instr=ROM[0x020] two edges later; instr_count increments by 1.
- Halt with simultaneous branch: transfer at pc=7 with halt_req=1, branch_taken=1, target 0x100 -> done=1, instr_valid=0, pc stays 7; later start pulse -> done=0, pc=0, instr_count=0, refetch begins.
- PC wrap: branch to 0x3FF, accept without branch -> pc=0x000.
- Counter saturation: force/preload instr_count to 0xFFFF, one more transfer -> count stays 0xFFFF.
- Async reset mid-HOLD with instr_valid=1: assert rst_n=0 between clock edges -> instr_valid, done, pc, instr and instr_count read 0 immediately, and state is IDLE after release.
